// File: rtl/mmc1_serial_mapper_pkg.sv
// -----------------------------------------------------------------------------
// mmc1_pkg
// Shared types and constants for the MMC1 serial-load mapper.
//   reg_idx_t     : bank register selected by CPU A[14:13]
//   CTRL_RST      : power-on / reset value of the control register
//   SST_OFS_*     : save-state register offsets relative to SST_BASE
//   prg_mode_map(): low four bits of the 16K PRG bank for a given PRG mode
// -----------------------------------------------------------------------------
package mmc1_pkg;

   typedef enum logic [1:0] {
      REG_CTRL = 2'd0,
      REG_CHR0 = 2'd1,
      REG_CHR1 = 2'd2,
      REG_PRG  = 2'd3
   } reg_idx_t;

   localparam logic [4:0] CTRL_RST = 5'h1F;
   localparam logic [2:0] BIT_LAST = 3'd4;

   localparam logic [7:0] SST_OFS_CTRL = 8'd0;
   localparam logic [7:0] SST_OFS_CHR0 = 8'd1;
   localparam logic [7:0] SST_OFS_CHR1 = 8'd2;
   localparam logic [7:0] SST_OFS_PRG  = 8'd3;
   localparam logic [7:0] SST_OFS_SREG = 8'd4;
   localparam logic [7:0] SST_OFS_CTR  = 8'd5;
   localparam logic [7:0] SST_OFS_PREV = 8'd6;

   // mode = ctrl[3:2]: 0x -> 32K switch, 10 -> first bank fixed, 11 -> last bank fixed
   function automatic logic [3:0] prg_mode_map(input logic [1:0] mode,
                                               input logic [3:0] prg,
                                               input logic       a14);
      logic [3:0] bank;
      case (mode)
         2'b00, 2'b01: bank = {prg[3:1], a14};
         2'b10:        bank = a14 ? prg : 4'h0;
         default:      bank = a14 ? 4'hF : prg;
      endcase
      return bank;
   endfunction

endpackage

// File: rtl/mmc1_serial_mapper_if.sv
// -----------------------------------------------------------------------------
// mmc1_serial_mapper_if
// Console-side bus bundle of the MMC1 mapper.
//   CPU side : cpu_m2, cpu_ce_n, cpu_rw, cpu_addr (A[14:13]), cpu_dat
//   PPU side : ppu_addr (A[12:10])
//   Mapped   : prg_ce_n, wram_ce, wram_bank, prg_addr, chr_addr, ciram_a10
// modport master : the console (drives CPU/PPU, receives mapped outputs)
// modport slave  : the mapper
// -----------------------------------------------------------------------------
interface mmc1_serial_mapper_if #(
   parameter int PRG_AW  = 5,
   parameter int CHR_AW  = 5,
   parameter int WRAM_BW = 2
);
   localparam int WB_W = (WRAM_BW > 0) ? WRAM_BW : 1;

   logic              cpu_m2;
   logic              cpu_ce_n;
   logic              cpu_rw;
   logic [1:0]        cpu_addr;
   logic [7:0]        cpu_dat;
   logic [2:0]        ppu_addr;

   logic              prg_ce_n;
   logic              wram_ce;
   logic [WB_W-1:0]   wram_bank;
   logic [PRG_AW-1:0] prg_addr;
   logic [CHR_AW-1:0] chr_addr;
   logic              ciram_a10;

   modport master (
      output cpu_m2, cpu_ce_n, cpu_rw, cpu_addr, cpu_dat, ppu_addr,
      input  prg_ce_n, wram_ce, wram_bank, prg_addr, chr_addr, ciram_a10
   );

   modport slave (
      input  cpu_m2, cpu_ce_n, cpu_rw, cpu_addr, cpu_dat, ppu_addr,
      output prg_ce_n, wram_ce, wram_bank, prg_addr, chr_addr, ciram_a10
   );
endinterface

// File: rtl/mmc1_serial_mapper_shift_loader.sv
// -----------------------------------------------------------------------------
// mmc1_shift_loader
// Serial-load front end: synchronises cpu_m2, detects its falling edge,
// filters RMW double writes and assembles the 5-bit shift register.
//   clk, rst_n, map_rst        : clock, async reset, sync soft reset
//   cpu_m2..cpu_dat            : raw CPU bus (sampled on the M2 fall)
//   sst_act                    : freezes loader state, suppresses CPU writes
//   sst_wr_sreg/ctr/prev       : save-state write strobes, data in sst_dato
//   commit_vld/idx/dat         : one-clk strobe loading a bank register
//   reset_pulse                : one-clk strobe for a D7=1 write
//   sreg, bit_ctr, prev_wr     : loader state, exposed for save-state reads
// -----------------------------------------------------------------------------
module mmc1_shift_loader
   import mmc1_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       map_rst,
   input  logic       cpu_m2,
   input  logic       cpu_ce_n,
   input  logic       cpu_rw,
   input  logic [1:0] cpu_addr,
   input  logic [7:0] cpu_dat,
   input  logic       sst_act,
   input  logic       sst_wr_sreg,
   input  logic       sst_wr_ctr,
   input  logic       sst_wr_prev,
   input  logic [7:0] sst_dato,
   output logic       commit_vld,
   output reg_idx_t   commit_idx,
   output logic [4:0] commit_dat,
   output logic       reset_pulse,
   output logic [4:0] sreg,
   output logic [2:0] bit_ctr,
   output logic       prev_wr
);

   logic       m2_p0, m2_p1, m2_p2;
   logic       m2_fall, cpu_wr, cpu_act, shift_en;
   logic [4:0] shift_next;
   logic       unused_bits;

   // M2 synchroniser (p0, p1) and edge-detect delay (p2)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2_p0 <= 1'b0;
         m2_p1 <= 1'b0;
         m2_p2 <= 1'b0;
      end else if (map_rst) begin
         m2_p0 <= 1'b0;
         m2_p1 <= 1'b0;
         m2_p2 <= 1'b0;
      end else begin
         m2_p0 <= cpu_m2;
         m2_p1 <= m2_p0;
         m2_p2 <= m2_p1;
      end
   end

   assign m2_fall     = m2_p2 & ~m2_p1;
   assign cpu_wr      = ~cpu_ce_n & ~cpu_rw;
   assign cpu_act     = m2_fall & ~sst_act;
   assign shift_next  = {cpu_dat[0], sreg[4:1]};
   // D7 reset is not subject to the RMW filter
   assign reset_pulse = cpu_act & cpu_wr & cpu_dat[7];
   assign shift_en    = cpu_act & cpu_wr & ~cpu_dat[7] & ~prev_wr;
   assign commit_vld  = shift_en & (bit_ctr >= BIT_LAST);
   assign commit_idx  = reg_idx_t'(cpu_addr);
   assign commit_dat  = shift_next;
   assign unused_bits = ^{cpu_dat[6:1], sst_dato[7:5]};

   // Save-state writes take priority over the soft reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg    <= 5'h00;
         bit_ctr <= 3'd0;
         prev_wr <= 1'b0;
      end else begin
         if (sst_wr_sreg)                               sreg <= sst_dato[4:0];
         else if (map_rst || reset_pulse || commit_vld) sreg <= 5'h00;
         else if (shift_en)                             sreg <= shift_next;

         if (sst_wr_ctr)                                bit_ctr <= sst_dato[2:0];
         else if (map_rst || reset_pulse || commit_vld) bit_ctr <= 3'd0;
         else if (shift_en)                             bit_ctr <= bit_ctr + 3'd1;

         if (sst_wr_prev)  prev_wr <= sst_dato[0];
         else if (map_rst) prev_wr <= 1'b0;
         else if (cpu_act) prev_wr <= cpu_wr;
      end
   end

endmodule

// File: rtl/mmc1_serial_mapper.sv
// -----------------------------------------------------------------------------
// mmc1_serial_mapper
// MMC1 serial-load mapper (SNROM/SOROM/SUROM/SXROM), system-clock domain.
//   clk, rst_n     : system clock, async active-low reset
//   map_rst        : sync console reset, same effect as rst_n
//   bus            : mmc1_serial_mapper_if.slave (CPU/PPU bus, bank outputs)
//   sst_act        : save-state mode, blocks CPU writes
//   sst_we/addr    : save-state register write strobe and address
//   sst_dato       : save-state write data
//   sst_di         : save-state read data, 0xFF outside SST_BASE+0..6
// Build option MMC1_WRAM_PROTECT_EN: when defined, prg[4]=1 disables WRAM
// (MMC1B); when undefined prg[4] only is stored (MMC1A).
// -----------------------------------------------------------------------------
module mmc1_serial_mapper
   import mmc1_pkg::*;
#(
   parameter int         PRG_AW   = 5,
   parameter int         CHR_AW   = 5,
   parameter int         WRAM_BW  = 2,
   parameter logic [7:0] SST_BASE = 8'h00
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 map_rst,
   mmc1_serial_mapper_if.slave  bus,
   input  logic                 sst_act,
   input  logic                 sst_we,
   input  logic [7:0]           sst_addr,
   input  logic [7:0]           sst_dato,
   output logic [7:0]           sst_di
);

   logic [4:0] bank_q [4];
   logic [4:0] ctrl, chr0, chr1, prg;
   logic       commit_vld, reset_pulse;
   reg_idx_t   commit_idx;
   logic [4:0] commit_dat, sreg;
   logic [2:0] bit_ctr;
   logic       prev_wr;
   logic [7:0] sst_ofs;
   logic [4:0] chr_sel, chr_full, prg_full;
   logic       ciram, wram_en;
   logic       unused_top;

   assign sst_ofs = sst_addr - SST_BASE;

   mmc1_shift_loader u_loader (
      .clk         (clk),
      .rst_n       (rst_n),
      .map_rst     (map_rst),
      .cpu_m2      (bus.cpu_m2),
      .cpu_ce_n    (bus.cpu_ce_n),
      .cpu_rw      (bus.cpu_rw),
      .cpu_addr    (bus.cpu_addr),
      .cpu_dat     (bus.cpu_dat),
      .sst_act     (sst_act),
      .sst_wr_sreg (sst_we && sst_ofs == SST_OFS_SREG),
      .sst_wr_ctr  (sst_we && sst_ofs == SST_OFS_CTR),
      .sst_wr_prev (sst_we && sst_ofs == SST_OFS_PREV),
      .sst_dato    (sst_dato),
      .commit_vld  (commit_vld),
      .commit_idx  (commit_idx),
      .commit_dat  (commit_dat),
      .reset_pulse (reset_pulse),
      .sreg        (sreg),
      .bit_ctr     (bit_ctr),
      .prev_wr     (prev_wr)
   );

   // Bank registers; array index equals both reg_idx_t and SST offset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++)
            bank_q[i] <= (i == int'(REG_CTRL)) ? CTRL_RST : 5'h00;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sst_we && sst_ofs == 8'(i))
               bank_q[i] <= sst_dato[4:0];
            else if (map_rst)
               bank_q[i] <= (i == int'(REG_CTRL)) ? CTRL_RST : 5'h00;
            else if (commit_vld && int'(commit_idx) == i)
               bank_q[i] <= commit_dat;
            else if (reset_pulse && i == int'(REG_CTRL))
               bank_q[i][3:2] <= 2'b11;
         end
      end
   end

   assign ctrl = bank_q[REG_CTRL];
   assign chr0 = bank_q[REG_CHR0];
   assign chr1 = bank_q[REG_CHR1];
   assign prg  = bank_q[REG_PRG];

   always_comb begin
      sst_di = 8'hFF;
      case (sst_ofs)
         SST_OFS_CTRL: sst_di = {3'b000, ctrl};
         SST_OFS_CHR0: sst_di = {3'b000, chr0};
         SST_OFS_CHR1: sst_di = {3'b000, chr1};
         SST_OFS_PRG:  sst_di = {3'b000, prg};
         SST_OFS_SREG: sst_di = {3'b000, sreg};
         SST_OFS_CTR:  sst_di = {5'b00000, bit_ctr};
         SST_OFS_PREV: sst_di = {7'b0000000, prev_wr};
         default:      sst_di = 8'hFF;
      endcase
   end

   always_comb begin
      ciram = 1'b0;
      case (ctrl[1:0])
         2'd0:    ciram = 1'b0;
         2'd1:    ciram = 1'b1;
         2'd2:    ciram = bus.ppu_addr[0];
         default: ciram = bus.ppu_addr[1];
      endcase
   end

`ifdef MMC1_WRAM_PROTECT_EN
   assign wram_en = ~prg[4];
`else
   assign wram_en = 1'b1;
`endif

   // chr_sel also drives the SUROM/SXROM outer PRG bank and WRAM bank bits
   assign chr_sel  = (~ctrl[4] | ~bus.ppu_addr[2]) ? chr0 : chr1;
   assign chr_full = ctrl[4] ? chr_sel : {chr0[4:1], bus.ppu_addr[2]};
   assign prg_full = {chr_sel[4], prg_mode_map(ctrl[3:2], prg[3:0], bus.cpu_addr[1])};

   assign bus.chr_addr  = chr_full[CHR_AW-1:0];
   assign bus.prg_addr  = prg_full[PRG_AW-1:0];
   assign bus.ciram_a10 = ciram;
   assign bus.prg_ce_n  = ~(~bus.cpu_ce_n & bus.cpu_rw);
   assign bus.wram_ce   = bus.cpu_ce_n & (bus.cpu_addr == 2'b11) & wram_en;

   generate
      if (WRAM_BW == 0) begin : g_wram_none
         assign bus.wram_bank = 1'b0;
      end else begin : g_wram_bank
         assign bus.wram_bank = chr_sel[2 +: WRAM_BW];
      end
   endgenerate

   assign unused_top = ^{sst_dato[7:5], prg[4]};

endmodule

// File: tb/tb_mmc1_serial_mapper.sv
module tb_mmc1_serial_mapper;
   localparam int         PRG_AW   = 5;
   localparam int         CHR_AW   = 5;
   localparam int         WRAM_BW  = 2;
   localparam logic [7:0] SST_BASE = 8'h10;

   logic       clk = 1'b0;
   logic       rst_n, map_rst, sst_act, sst_we;
   logic [7:0] sst_addr, sst_dato, sst_di, rd;
   int         n_checks = 0;
   int         n_err    = 0;

   // reference model state: 0 ctrl, 1 chr0, 2 chr1, 3 prg
   int m_reg [4];
   int m_sreg, m_cnt, m_prev;

   always #5 clk = ~clk;

   mmc1_serial_mapper_if #(.PRG_AW(PRG_AW), .CHR_AW(CHR_AW), .WRAM_BW(WRAM_BW)) bus ();

   mmc1_serial_mapper #(.PRG_AW(PRG_AW), .CHR_AW(CHR_AW), .WRAM_BW(WRAM_BW), .SST_BASE(SST_BASE)) dut (
      .clk(clk), .rst_n(rst_n), .map_rst(map_rst), .bus(bus),
      .sst_act(sst_act), .sst_we(sst_we), .sst_addr(sst_addr),
      .sst_dato(sst_dato), .sst_di(sst_di)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_reg[0] = 'h1F; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 0;
      m_sreg = 0; m_cnt = 0; m_prev = 0;
   endtask

   // one CPU bus cycle as seen by the mapper
   task automatic model_cycle(input int ce_n, input int rw, input int a, input int d, input int act);
      int wr, nxt;
      if (act) return;
      wr = (ce_n == 0 && rw == 0) ? 1 : 0;
      if (wr == 1) begin
         if (((d >> 7) & 1) == 1) begin
            m_sreg = 0; m_cnt = 0; m_reg[0] = m_reg[0] | 'hC;
         end else if (m_prev == 0) begin
            nxt = (m_sreg >> 1) | ((d & 1) << 4);
            if (m_cnt < 4) begin
               m_sreg = nxt; m_cnt = m_cnt + 1;
            end else begin
               m_reg[a] = nxt; m_sreg = 0; m_cnt = 0;
            end
         end
      end
      m_prev = wr;
   endtask

   function automatic int e_sst(input int o);
      case (o)
         0, 1, 2, 3: return m_reg[o];
         4: return m_sreg;
         5: return m_cnt;
         6: return m_prev;
         default: return 'hFF;
      endcase
   endfunction

   function automatic int e_sel(input int p);
      if (((m_reg[0] >> 4) & 1) == 0 || ((p >> 2) & 1) == 0) return m_reg[1];
      return m_reg[2];
   endfunction

   function automatic int e_ciram(input int p);
      case (m_reg[0] & 3)
         0: return 0;
         1: return 1;
         2: return p & 1;
         default: return (p >> 1) & 1;
      endcase
   endfunction

   function automatic int e_chr(input int p);
      if (((m_reg[0] >> 4) & 1) == 0) return ((m_reg[1] & 'h1E) | ((p >> 2) & 1)) % (1 << CHR_AW);
      return e_sel(p) % (1 << CHR_AW);
   endfunction

   function automatic int e_prg(input int p, input int a);
      int a14, pr, mode, lo;
      a14 = (a >> 1) & 1; pr = m_reg[3] & 15; mode = (m_reg[0] >> 2) & 3;
      if (mode < 2)       lo = (pr & 14) | a14;
      else if (mode == 2) lo = a14 ? pr : 0;
      else                lo = a14 ? 15 : pr;
      if (PRG_AW == 5) lo = lo + ((e_sel(p) >> 4) & 1) * 16;
      return lo;
   endfunction

   function automatic int e_wce(input int ce_n, input int a);
      int ok;
`ifdef MMC1_WRAM_PROTECT_EN
      ok = (((m_reg[3] >> 4) & 1) == 0) ? 1 : 0;
`else
      ok = 1;
`endif
      return (ce_n == 1 && a == 3 && ok == 1) ? 1 : 0;
   endfunction

   task automatic cpu_cycle(input int ce_n, input int rw, input int a, input int d, input int act);
      @(negedge clk);
      bus.cpu_ce_n = 1'(ce_n); bus.cpu_rw = 1'(rw);
      bus.cpu_addr = 2'(a); bus.cpu_dat = 8'(d);
      sst_act = 1'(act);
      bus.cpu_m2 = 1'b1;
      repeat (3) @(negedge clk);
      bus.cpu_m2 = 1'b0;
      repeat (5) @(negedge clk);
      model_cycle(ce_n, rw, a, d, act);
   endtask

   task automatic cpu_write(input int a, input int d, input int act);
      cpu_cycle(0, 1, $urandom_range(0, 3), $urandom_range(0, 255), act);
      cpu_cycle(0, 0, a, d, act);
   endtask

   task automatic serial_load(input int a, input int v, input int act);
      for (int i = 0; i < 5; i++) cpu_write(a, (v >> i) & 1, act);
   endtask

   task automatic sst_rd(input int o, output logic [7:0] v);
      @(negedge clk);
      sst_addr = 8'(int'(SST_BASE) + o);
      #1 v = sst_di;
   endtask

   task automatic sst_wr(input int o, input int v);
      @(negedge clk);
      sst_we = 1'b1; sst_addr = 8'(int'(SST_BASE) + o); sst_dato = 8'(v);
      @(negedge clk);
      sst_we = 1'b0;
      case (o)
         0, 1, 2, 3: m_reg[o] = v & 'h1F;
         4: m_sreg = v & 'h1F;
         5: m_cnt = v & 7;
         6: m_prev = v & 1;
         default: ;
      endcase
   endtask

   task automatic check_regs();
      for (int o = 0; o < 8; o++) begin
         sst_rd(o, rd);
         chk($sformatf("sst_ofs%0d", o), rd, e_sst(o));
      end
   endtask

   task automatic check_map();
      int a, ce, rw;
      for (int p = 0; p < 8; p++) begin
         @(negedge clk);
         a = $urandom_range(0, 3); ce = $urandom_range(0, 1); rw = $urandom_range(0, 1);
         bus.ppu_addr = 3'(p); bus.cpu_addr = 2'(a); bus.cpu_ce_n = 1'(ce); bus.cpu_rw = 1'(rw);
         #1;
         chk($sformatf("ciram_p%0d", p), bus.ciram_a10, e_ciram(p));
         chk($sformatf("chr_p%0d", p), bus.chr_addr, e_chr(p));
         chk($sformatf("prg_p%0d_a%0d", p, a), bus.prg_addr, e_prg(p, a));
         chk($sformatf("wbank_p%0d", p), bus.wram_bank, (e_sel(p) >> 2) & ((1 << WRAM_BW) - 1));
         chk($sformatf("wram_ce_a%0d", a), bus.wram_ce, e_wce(ce, a));
         chk("prg_ce_n", bus.prg_ce_n, (ce == 0 && rw == 1) ? 0 : 1);
      end
   endtask

   initial begin
      int ce, rw, a, d, act;
      rst_n = 1'b0; map_rst = 1'b0; sst_act = 1'b0; sst_we = 1'b0;
      sst_addr = 8'h00; sst_dato = 8'h00;
      bus.cpu_m2 = 1'b0; bus.cpu_ce_n = 1'b1; bus.cpu_rw = 1'b1;
      bus.cpu_addr = 2'b00; bus.cpu_dat = 8'h00; bus.ppu_addr = 3'b000;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      check_regs();
      check_map();

      // 5'h05 serially into PRG at $E000, ctrl still 1F
      serial_load(3, 'h05, 0);
      check_regs();
      @(negedge clk);
      bus.ppu_addr = 3'b000; bus.cpu_addr = 2'b00; #1;
      chk("prg_a14_0", bus.prg_addr, 'h05);
      bus.cpu_addr = 2'b10; #1;
      chk("prg_a14_1", bus.prg_addr, 'h0F);

      // D7 reset mid-sequence
      serial_load(0, 'h10, 0);
      for (int i = 0; i < 3; i++) cpu_write(0, i & 1, 0);
      sst_rd(5, rd); chk("ctr_after3", rd, 3);
      cpu_write(0, 'h80, 0);
      sst_rd(5, rd); chk("ctr_d7", rd, 0);
      sst_rd(4, rd); chk("sreg_d7", rd, 0);
      sst_rd(0, rd); chk("ctrl_d7", rd, 'h1C);
      serial_load(0, 'h0E, 0);
      sst_rd(0, rd); chk("ctrl_reload", rd, 'h0E);

      // RMW back-to-back writes
      cpu_cycle(0, 1, 0, 0, 0);
      cpu_cycle(0, 0, 0, 'h00, 0);
      cpu_cycle(0, 0, 0, 'h01, 0);
      sst_rd(5, rd); chk("rmw_ctr", rd, 1);
      sst_rd(4, rd); chk("rmw_sreg", rd, 0);
      cpu_write(0, 'h80, 0);
      check_regs();

      // 4K CHR mode with outer PRG bank from CHR
      serial_load(0, 'h10, 0);
      serial_load(1, 'h13, 0);
      serial_load(2, 'h02, 0);
      @(negedge clk);
      bus.ppu_addr = 3'b000; #1;
      chk("chr_a12_0", bus.chr_addr, 'h13);
      chk("outer_a12_0", bus.prg_addr[4], 1);
      bus.ppu_addr = 3'b100; #1;
      chk("chr_a12_1", bus.chr_addr, 'h02);
      chk("outer_a12_1", bus.prg_addr[4], 0);
      check_map();

      // WRAM protect bit
      serial_load(3, 'h10, 0);
      @(negedge clk);
      bus.cpu_ce_n = 1'b1; bus.cpu_addr = 2'b11; bus.cpu_rw = 1'b1; #1;
`ifdef MMC1_WRAM_PROTECT_EN
      chk("wram_ce_prot", bus.wram_ce, 0);
`else
      chk("wram_ce_prot", bus.wram_ce, 1);
`endif
      check_map();

      // save-state writes, CPU blocked
      @(negedge clk); sst_act = 1'b1;
      for (int o = 0; o < 5; o++) sst_wr(o, $urandom_range(0, 255));
      sst_wr(5, 'hFC);
      sst_wr(6, $urandom_range(0, 255));
      serial_load(3, 'h1A, 1);
      cpu_write(0, 'h80, 1);
      check_regs();
      sst_rd(5, rd); chk("ctr_trunc", rd, 4);
      @(negedge clk); sst_act = 1'b0;
      sst_wr(5, 0);
      sst_wr(6, 0);

      // SST write beats map_rst in the same clock
      @(negedge clk);
      sst_we = 1'b1; sst_addr = 8'(int'(SST_BASE) + 2); sst_dato = 8'h0B; map_rst = 1'b1;
      @(negedge clk);
      sst_we = 1'b0; map_rst = 1'b0;
      model_reset(); m_reg[2] = 'h0B;
      check_regs();

      // randomized bus traffic
      for (int n = 0; n < 240; n++) begin
         ce  = ($urandom_range(0, 3) == 0) ? 1 : 0;
         rw  = $urandom_range(0, 1);
         a   = $urandom_range(0, 3);
         d   = ($urandom_range(0, 15) == 0 ? 'h80 : 0) | ($urandom_range(0, 63) << 1) | $urandom_range(0, 1);
         act = ($urandom_range(0, 11) == 0) ? 1 : 0;
         cpu_cycle(ce, rw, a, d, act);
         sst_act = 1'b0;
         if (n % 12 == 11) begin
            check_regs();
            check_map();
         end
      end

      // soft reset
      @(negedge clk); map_rst = 1'b1;
      @(negedge clk); map_rst = 1'b0;
      model_reset();
      check_regs();
      check_map();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
